// File: rtl/ascii_glyph_render.sv
// Expands one density/edge code into a TILE_WIDTH x TILE_HEIGHT pixel tile,
// streamed in raster order over a valid/ready pixel interface.
module ascii_glyph_render #(
    parameter int TILE_WIDTH   = 8,
    parameter int TILE_HEIGHT  = 8,
    parameter int ASCII_LEVELS = 8,
    parameter int COLORS       = 3,
    parameter int COLOR_DEPTH  = 8,
    parameter int DATA_WIDTH   = COLORS * COLOR_DEPTH,
    parameter logic [DATA_WIDTH-1:0] FG_COLOR   = 24'hFFFFFF,
    parameter logic [DATA_WIDTH-1:0] BG_COLOR   = 24'h000000,
    parameter logic [DATA_WIDTH-1:0] EDGE_COLOR = 24'hFF0000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic [$clog2(ASCII_LEVELS)-1:0] ascii,
    input  logic                            edge_exists,
    input  logic                            ascii_valid,
    output logic                            ascii_accept,
    output logic [DATA_WIDTH-1:0]           pix_data,
    output logic [$clog2(TILE_WIDTH)-1:0]   pix_x,
    output logic [$clog2(TILE_HEIGHT)-1:0]  pix_y,
    output logic                            pix_valid,
    input  logic                            pix_ready,
    output logic                            tile_last
);

    localparam int XW = $clog2(TILE_WIDTH);
    localparam int YW = $clog2(TILE_HEIGHT);
    localparam int LW = $clog2(ASCII_LEVELS);
    // Wide enough for idx*(LEVELS-1) and L*W*H without overflow.
    localparam int CW = $clog2(TILE_WIDTH * TILE_HEIGHT * ASCII_LEVELS) + 1;

    localparam logic [XW-1:0] X_LAST = XW'(TILE_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(TILE_HEIGHT - 1);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_RENDER = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [LW-1:0]         lvl_q, lvl_d;
    logic                  edge_q, edge_d;
    logic                  pix_valid_q, pix_valid_d;
    logic                  tile_last_q, tile_last_d;
    logic [DATA_WIDTH-1:0] pix_data_q, pix_data_d;

    logic take_code;
    logic pix_fire;

    function automatic logic [DATA_WIDTH-1:0] glyph_color(
        input logic [XW-1:0] gx,
        input logic [YW-1:0] gy,
        input logic [LW-1:0] glvl,
        input logic          gedge
    );
        logic [CW-1:0] idx;
        logic [CW-1:0] lhs;
        logic [CW-1:0] rhs;
        logic          lit;
        idx = CW'(gy) * CW'(TILE_WIDTH) + CW'(gx);
        lhs = idx * CW'(ASCII_LEVELS - 1);
        rhs = CW'(glvl) * CW'(TILE_WIDTH * TILE_HEIGHT);
        if (gedge) begin
            lit = (CW'(gx) == CW'(gy)) || ((CW'(gx) + CW'(gy)) == CW'(TILE_WIDTH - 1));
            glyph_color = lit ? EDGE_COLOR : BG_COLOR;
        end else begin
            lit = (lhs < rhs);
            glyph_color = lit ? FG_COLOR : BG_COLOR;
        end
    endfunction

    assign ascii_accept = enable && ((state_q == S_IDLE) || (tile_last_q && pix_valid_q && pix_ready));
    assign take_code    = ascii_valid && ascii_accept;
    assign pix_fire     = pix_valid_q && pix_ready;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a code taken on the last handshake chains straight into the next tile
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (take_code) begin
                    state_d = S_RENDER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RENDER: begin
                if (pix_fire && tile_last_q && !take_code) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RENDER;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Position and latched code update
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        lvl_d  = lvl_q;
        edge_d = edge_q;
        if (take_code) begin
            x_d    = {XW{1'b0}};
            y_d    = {YW{1'b0}};
            lvl_d  = ascii;
            edge_d = edge_exists;
        end else if (pix_fire) begin
            if (x_q == X_LAST) begin
                x_d = {XW{1'b0}};
                y_d = (y_q == Y_LAST) ? {YW{1'b0}} : (y_q + YW'(1));
            end else begin
                x_d = x_q + XW'(1);
                y_d = y_q;
            end
        end else begin
            x_d = x_q;
            y_d = y_q;
        end
    end

    // FSM outputs, evaluated on next-cycle values so the pixel port is registered
    always_comb begin
        pix_valid_d = (state_d == S_RENDER);
        tile_last_d = 1'b0;
        pix_data_d  = {DATA_WIDTH{1'b0}};
        if (pix_valid_d) begin
            tile_last_d = (x_d == X_LAST) && (y_d == Y_LAST);
            pix_data_d  = glyph_color(x_d, y_d, lvl_d, edge_d);
        end else begin
            tile_last_d = 1'b0;
            pix_data_d  = {DATA_WIDTH{1'b0}};
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= {XW{1'b0}};
            y_q         <= {YW{1'b0}};
            lvl_q       <= {LW{1'b0}};
            edge_q      <= 1'b0;
            pix_valid_q <= 1'b0;
            tile_last_q <= 1'b0;
            pix_data_q  <= {DATA_WIDTH{1'b0}};
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            lvl_q       <= lvl_d;
            edge_q      <= edge_d;
            pix_valid_q <= pix_valid_d;
            tile_last_q <= tile_last_d;
            pix_data_q  <= pix_data_d;
        end
    end

    assign pix_x     = x_q;
    assign pix_y     = y_q;
    assign pix_valid = pix_valid_q;
    assign tile_last = tile_last_q;
    assign pix_data  = pix_data_q;

endmodule

// File: doc/ascii_glyph_render.md
ASCII_GLYPH_RENDER -- requirements
Module: ascii_glyph_render

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  TILE_WIDTH, 8, glyph columns.
  TILE_HEIGHT, 8, glyph rows.
  ASCII_LEVELS, 8, number of density levels.
  COLORS, 3, channels per pixel.
  COLOR_DEPTH, 8, bits per channel.
  DATA_WIDTH, COLORS*COLOR_DEPTH, pixel width.
  FG_COLOR, 24'hFFFFFF, lit density pixel.
  BG_COLOR, 24'h000000, unlit pixel.
  EDGE_COLOR, 24'hFF0000, lit edge pixel.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  sole clock.
  rst  in  1  asynchronous, active-high reset.
  enable  in  1  gates acceptance of new codes.
  ascii  in  $clog2(ASCII_LEVELS)  density level.
  edge_exists  in  1  render edge glyph.
  ascii_valid  in  1  code offered.
  ascii_accept  out  1  code taken this cycle.
  pix_data  out  DATA_WIDTH  pixel color.
  pix_x  out  $clog2(TILE_WIDTH)  column.
  pix_y  out  $clog2(TILE_HEIGHT)  row.
  pix_valid  out  1  pixel presented.
  pix_ready  in  1  downstream takes pixel.
  tile_last  out  1  final pixel of tile.

Function
REQ-003 The FSM SHALL have two states: IDLE and RENDER.
REQ-004 ascii_accept SHALL be combinational: enable && (state==IDLE || (tile_last && pix_valid && pix_ready)).
REQ-005 A code is taken when ascii_valid && ascii_accept; ascii and edge_exists SHALL be latched on that edge, x=y=0, and the state SHALL be RENDER.
REQ-006 In RENDER, pix_valid SHALL be 1; in IDLE it SHALL be 0; the first pixel SHALL be valid the cycle after acceptance (latency 1).
REQ-007 The pixel position SHALL advance only on pix_valid && pix_ready, in raster order: x increments, and on x==TILE_WIDTH-1 it wraps to 0 and y increments.
REQ-008 While pix_ready is low, pix_data, pix_x, pix_y and tile_last SHALL hold stable.
REQ-009 tile_last SHALL be 1 iff in RENDER with x==TILE_WIDTH-1 and y==TILE_HEIGHT-1.
REQ-010 On the tile_last handshake:
  - if a code is taken in the same cycle, SHALL stay in RENDER at x=y=0 with the new code (no bubble);
  - otherwise SHALL go to IDLE.
REQ-011 Density glyph (latched edge=0): with i=y*TILE_WIDTH+x, a pixel SHALL be lit iff i*(ASCII_LEVELS-1) < L*TILE_WIDTH*TILE_HEIGHT, where L is the latched level.
REQ-012 Lit density pixels SHALL be FG_COLOR; unlit pixels SHALL be BG_COLOR.
REQ-013 Edge glyph (latched edge=1): a pixel SHALL be lit iff x==y or x+y==TILE_WIDTH-1; lit pixels SHALL be EDGE_COLOR, others BG_COLOR.
REQ-014 The arithmetic in REQ-011 SHALL be computed at a width sufficient that it never overflows: at least $clog2(TILE_WIDTH*TILE_HEIGHT*ASCII_LEVELS)+1 bits.
REQ-015 Deasserting enable mid-tile SHALL NOT abort the tile; it only blocks new acceptance.
REQ-016 ascii and edge_exists changing during RENDER SHALL NOT affect the tile in progress.
REQ-017 pix_data SHALL be 0 whenever pix_valid is 0.

Reset
REQ-018 rst high SHALL immediately force state=IDLE, x=y=0, latched code=0, latched edge=0, pix_valid=0, tile_last=0 and pix_data=0, independent of clk.
REQ-019 Reset asserted mid-tile SHALL abort the tile with no further pixels; after release the block SHALL be ready to accept when enable is high.

Verification
REQ-020 Level 0 with pix_ready held at 1 -> 64 pixels on consecutive cycles, all 24'h000000; tile_last only on (7,7); IDLE after.
REQ-021 Level 1, then level 7 -> level 1 has pixels i=0..9 at 24'hFFFFFF and i=10..63 at 0; level 7 has all 64 pixels at 24'hFFFFFF.
REQ-022 edge_exists=1 -> 16 pixels at 24'hFF0000 (both diagonals), 48 pixels at 0.
REQ-023 pix_ready toggling 1,0,1,0 with a new code presented on the last pixel -> every pixel held while stalled, no skipped or duplicated (x,y), second tile pixel (0,0) on the cycle after the first tile's tile_last handshake.
REQ-024 rst pulsed at pixel (3,2) -> pix_valid=0 that cycle, asynchronously; after release, level 7 accepted and rendering restarts at (0,0).
REQ-025 enable=0 with ascii_valid=1 -> ascii_accept stays 0 and no pixels are produced; enable dropped mid-tile -> the tile completes all 64 pixels.
